// File: rtl/fish_pkg.sv
// Shared definitions for the fishing game: phase codes, level count and LFSR constants.
// The pixel datapath imports the same phase codes.
package fish_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_WAIT = 3'd1,
    PH_SWIM = 3'd2,
    PH_REEL = 3'd3,
    PH_WIN  = 3'd4,
    PH_LOSE = 3'd5
  } phase_e;

  localparam int         NUM_LEVELS_DEF = 4;
  localparam logic [7:0] LFSR_SEED      = 8'hA5;
  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;

endpackage

// File: rtl/fish_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; seeded non-zero on reset so it never locks up.
module fish_lfsr8
  import fish_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/fish_level_sequencer.sv
// Game-flow scheduler: level sequencing, randomised spawn delay, hook/reel/escape, score and misses.
// Optional reel timeout is enabled by defining FISH_SEQ_TIMEOUT_EN.
module fish_level_sequencer
  import fish_pkg::*;
#(
  parameter int NUM_LEVELS     = NUM_LEVELS_DEF,
  parameter int SPAWN_MIN      = 30,
  parameter int SPAWN_MASK     = 63,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               hook_hit,
  input  logic               fish_surfaced,
  input  logic               fish_offscreen,
  output logic [2:0]         phase,
  output logic [1:0]         level,
  output logic               spawn,
  output logic [2:0]         fish_speed,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         misses
);

  localparam int DLY_MAX = SPAWN_MIN + SPAWN_MASK;
  localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

  phase_e             st, st_n;
  logic [1:0]         level_n, misses_n;
  logic [SCORE_W-1:0] score_n;
  logic [DLY_W-1:0]   dly, dly_n, dly_load;
  logic [SCORE_W:0]   score_sum;
  logic [7:0]         lfsr;
  logic               start_q, start_edge, spawn_go, do_miss, last_lvl;

`ifdef FISH_SEQ_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
  logic [TMR_W-1:0] tmr, tmr_n;
`endif

  fish_lfsr8 u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  assign start_edge = tick & start & ~start_q;
  assign dly_load   = DLY_W'(SPAWN_MIN + (int'(lfsr) & SPAWN_MASK));
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'({1'b0, level}) + (SCORE_W+1)'(1);
  assign last_lvl   = (level == 2'(NUM_LEVELS - 1));
  assign phase      = st;
  assign fish_speed = {1'b0, level} + 3'd1;

  // Every next-state term is gated by tick, so the registers below only move on frame ticks.
  always_comb begin
    st_n     = st;
    level_n  = level;
    score_n  = score;
    misses_n = misses;
    dly_n    = dly;
    spawn_go = 1'b0;
    do_miss  = 1'b0;
`ifdef FISH_SEQ_TIMEOUT_EN
    tmr_n    = tmr;
`endif
    if (tick) begin
      case (st)
        PH_IDLE: if (start_edge) begin
          level_n  = '0;
          score_n  = '0;
          misses_n = '0;
          dly_n    = dly_load;
          st_n     = PH_WAIT;
        end
        PH_WAIT: begin
          if (dly == '0) begin
            st_n     = PH_SWIM;
            spawn_go = 1'b1;
          end else begin
            dly_n = dly - DLY_W'(1);
          end
        end
        PH_SWIM: begin
          if (hook_hit) begin
            st_n = PH_REEL;
`ifdef FISH_SEQ_TIMEOUT_EN
            tmr_n = '0;
`endif
          end else if (fish_offscreen) begin
            do_miss = 1'b1;
          end
        end
        PH_REEL: begin
          if (fish_surfaced) begin
            score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (last_lvl) begin
              st_n = PH_WIN;
            end else begin
              level_n = level + 2'd1;
              dly_n   = dly_load;
              st_n    = PH_WAIT;
            end
          end
`ifdef FISH_SEQ_TIMEOUT_EN
          else if (tmr == TMR_W'(TIMEOUT_FRAMES - 1)) do_miss = 1'b1;
          else tmr_n = tmr + TMR_W'(1);
`endif
        end
        PH_WIN, PH_LOSE: if (start_edge) st_n = PH_IDLE;
        default: st_n = PH_IDLE;
      endcase
      if (do_miss) begin
        misses_n = misses + 2'd1;
        if (misses_n == 2'd3) begin
          st_n = PH_LOSE;
        end else begin
          dly_n = dly_load;
          st_n  = PH_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= PH_IDLE;
    else     st <= st_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= '0;
      score   <= '0;
      misses  <= '0;
      dly     <= '0;
      spawn   <= 1'b0;
      start_q <= 1'b0;
`ifdef FISH_SEQ_TIMEOUT_EN
      tmr     <= '0;
`endif
    end else begin
      level  <= level_n;
      score  <= score_n;
      misses <= misses_n;
      dly    <= dly_n;
      spawn  <= spawn_go;
      if (tick) start_q <= start;
`ifdef FISH_SEQ_TIMEOUT_EN
      tmr    <= tmr_n;
`endif
    end
  end

endmodule
